// File: rtl/root_accel_pkg.sv
// Shared mode codes, FSM encoding and width helpers for the root accelerator.
package root_accel_pkg;

    localparam logic [1:0] MODE_CBSQ = 2'b00;  // floor(sqrt(a + floor(cbrt(b))))
    localparam logic [1:0] MODE_SQ   = 2'b01;  // floor(sqrt(a))
    localparam logic [1:0] MODE_CB   = 2'b10;  // floor(cbrt(b))
    localparam logic [1:0] MODE_ALT  = 2'b11;  // behaves exactly like MODE_CBSQ

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CB_SQ   = 3'd1;
    localparam logic [2:0] ST_CB_CU   = 3'd2;
    localparam logic [2:0] ST_CB_CMP  = 3'd3;
    localparam logic [2:0] ST_ADD     = 3'd4;
    localparam logic [2:0] ST_SQ_INIT = 3'd5;
    localparam logic [2:0] ST_SQ_STEP = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        CB_SQ   = ST_CB_SQ,
        CB_CU   = ST_CB_CU,
        CB_CMP  = ST_CB_CMP,
        ADD     = ST_ADD,
        SQ_INIT = ST_SQ_INIT,
        SQ_STEP = ST_SQ_STEP,
        DONE    = ST_DONE
    } state_t;

    // Result bits of floor(cbrt(x)) for a w-bit x: ceil(w/3).
    function automatic int cb_bits(input int w);
        return (w + 2) / 3;
    endfunction

    // Result bits of floor(sqrt(x)) for a (w+1)-bit x: ceil((w+1)/2).
    function automatic int sb_bits(input int w);
        return (w + 2) / 2;
    endfunction

endpackage

// File: rtl/root_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, N cycles per
// product. A start pulse clears the accumulator and loads the operands, so the
// product stays readable on y_bo until the next start.
module root_mult #(
    parameter int N = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [N-1:0]     a_i,
    input  logic [N-1:0]     b_i,
    output logic             busy_o,
    output logic [2*N-1:0]   y_bo
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;

    // Load on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_bo     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_o   <= 1'b0;
        end else if (start_i) begin
            y_bo     <= '0;
            mcand_q  <= {{N{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= CW'(N);
            busy_o   <= 1'b1;
        end else if (busy_o) begin
            if (mplier_q[0]) begin
                y_bo <= y_bo + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/root_accel.sv
// Handshaked integer root unit: sqrt(a + cbrt(b)), sqrt(a) or cbrt(b) per
// request. Cube root is found bit by bit using the shared multiplier for the
// cand^3 trial; square root uses the classic digit-by-digit method inline.
// Latency depends only on W and mode, never on operand values.
module root_accel
    import root_accel_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [1:0]   mode_i,
    input  logic [W-1:0] a_bi,
    input  logic [W-1:0] b_bi,
    output logic         busy_o,
    output logic         valid_o,
    output logic [W-1:0] y_bo
);

    localparam int CB = cb_bits(W);
    localparam int SB = sb_bits(W);
    localparam int MW = 3 * CB;            // multiplier operand width
    localparam int PW = 2 * MW;            // multiplier product width
    localparam int XW = 2 * SB;            // radicand width, holds a + cbrt(b) with carry
    localparam int KW = $clog2(CB) + 1;

    localparam logic [XW-2:0] M_INIT = {1'b1, {(XW-2){1'b0}}};

    state_t        state_q, state_n;
    logic [1:0]    mode_q;
    logic [W-1:0]  a_q, b_q;
    logic [CB-1:0] r_cb_q;
    logic [KW-1:0] k_q;
    logic [XW-1:0] x_q;
    logic [XW-1:0] sr_q;
    logic [XW-2:0] m_q;
    logic [W-1:0]  y_q;
    logic          m_go_q, m_go_n;

    logic          m_busy;
    logic [MW-1:0] m_a, m_b;
    logic [PW-1:0] m_p;

    logic [CB-1:0] cand;
    logic          p_le_b;
    logic [CB-1:0] cb_r_n;
    logic [XW-1:0] sq_t;
    logic          sq_ge;
    logic [XW-1:0] sq_r_n;
    logic          sq_last;
    logic          accept;

    assign accept  = start_i && (state_q == IDLE || state_q == DONE);

    assign cand    = r_cb_q | (CB'(1) << k_q);
    assign p_le_b  = m_p <= PW'(b_q);
    assign cb_r_n  = p_le_b ? cand : r_cb_q;

    assign sq_t    = sr_q | XW'(m_q);
    assign sq_ge   = x_q >= sq_t;
    assign sq_r_n  = sq_ge ? ((sr_q >> 1) | XW'(m_q)) : (sr_q >> 1);
    assign sq_last = (m_q >> 2) == '0;

    // First trial squares cand; second trial multiplies that square by cand.
    assign m_a     = (state_q == CB_CU) ? m_p[MW-1:0] : MW'(cand);
    assign m_b     = MW'(cand);

    assign busy_o  = !(state_q == IDLE || state_q == DONE);
    assign valid_o = (state_q == DONE);
    assign y_bo    = y_q;

    root_mult #(.N(MW)) u_mult (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (m_go_q),
        .a_i     (m_a),
        .b_i     (m_b),
        .busy_o  (m_busy),
        .y_bo    (m_p)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; a multiplier start is requested on entry to each trial state.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_n = (mode_i == MODE_SQ) ? SQ_INIT : CB_SQ;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_n = (mode_i == MODE_SQ) ? SQ_INIT : CB_SQ;
                end else begin
                    state_n = IDLE;
                end
            end
            CB_SQ: begin
                if (!m_go_q && !m_busy) begin
                    state_n = CB_CU;
                end
            end
            CB_CU: begin
                if (!m_go_q && !m_busy) begin
                    state_n = CB_CMP;
                end
            end
            CB_CMP: begin
                if (k_q != '0) begin
                    state_n = CB_SQ;
                end else if (mode_q == MODE_CB) begin
                    state_n = DONE;
                end else begin
                    state_n = ADD;
                end
            end
            ADD:     state_n = SQ_INIT;
            SQ_INIT: state_n = SQ_STEP;
            SQ_STEP: begin
                if (sq_last) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
        m_go_n = ((state_n == CB_SQ) && (state_q != CB_SQ)) ||
                 ((state_n == CB_CU) && (state_q != CB_CU));
    end

    // Datapath registers: operand capture, cube-root and square-root iterations, result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= MODE_CBSQ;
            a_q    <= '0;
            b_q    <= '0;
            r_cb_q <= '0;
            k_q    <= '0;
            x_q    <= '0;
            sr_q   <= '0;
            m_q    <= '0;
            y_q    <= '0;
            m_go_q <= 1'b0;
        end else begin
            m_go_q <= m_go_n;
            if (accept) begin
                mode_q <= (mode_i == MODE_ALT) ? MODE_CBSQ : mode_i;
                a_q    <= a_bi;
                b_q    <= b_bi;
                r_cb_q <= '0;
                k_q    <= KW'(CB - 1);
                x_q    <= XW'(a_bi);
            end
            case (state_q)
                CB_CMP: begin
                    r_cb_q <= cb_r_n;
                    if (k_q != '0) begin
                        k_q <= k_q - KW'(1);
                    end else if (mode_q == MODE_CB) begin
                        y_q <= W'(cb_r_n);
                    end
                end
                ADD: begin
                    x_q <= XW'(a_q) + XW'(r_cb_q);
                end
                SQ_INIT: begin
                    sr_q <= '0;
                    m_q  <= M_INIT;
                end
                SQ_STEP: begin
                    if (sq_ge) begin
                        x_q <= x_q - sq_t;
                    end
                    sr_q <= sq_r_n;
                    m_q  <= m_q >> 2;
                    if (sq_last) begin
                        y_q <= W'(sq_r_n);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_root_accel.sv
// Scoreboard bench for root_accel at W=8, 16 and 32. Stimulus pushes the
// expected result per accepted request; per-instance monitors pop and compare
// on every valid_o pulse and track latency per effective mode.
module tb_root_accel;

    localparam int WAIT_LIM  = 5000;
    localparam int DRAIN_LIM = 20000;

    typedef struct packed {
        logic [31:0] y;
        logic [1:0]  md;
        logic [63:0] t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst8_n = 1'b0, rstw_n = 1'b0;
    logic        st8 = 1'b0, st16 = 1'b0, st32 = 1'b0;
    logic [1:0]  md8 = '0, md16 = '0, md32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy8, busy16, busy32;
    logic        vld8, vld16, vld32;
    logic [7:0]  y8;
    logic [15:0] y16;
    logic [31:0] y32;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q32[$];
    longint lat_ref[3][3];

    root_accel #(.W(8)) dut8 (
        .clk_i(clk), .rst_ni(rst8_n), .start_i(st8), .mode_i(md8),
        .a_bi(a8), .b_bi(b8), .busy_o(busy8), .valid_o(vld8), .y_bo(y8)
    );
    root_accel #(.W(16)) dut16 (
        .clk_i(clk), .rst_ni(rstw_n), .start_i(st16), .mode_i(md16),
        .a_bi(a16), .b_bi(b16), .busy_o(busy16), .valid_o(vld16), .y_bo(y16)
    );
    root_accel #(.W(32)) dut32 (
        .clk_i(clk), .rst_ni(rstw_n), .start_i(st32), .mode_i(md32),
        .a_bi(a32), .b_bi(b32), .busy_o(busy32), .valid_o(vld32), .y_bo(y32)
    );

    // Reference model, written independently of the RTL iteration scheme.
    function automatic longint icbrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic longint isqrt(input longint v);
        longint lo = 0;
        longint hi = 131071;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [31:0] ref_root(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b);
        longint la = longint'(a);
        longint lb = longint'(b);
        case (md)
            2'b01:   return 32'(isqrt(la));
            2'b10:   return 32'(icbrt(lb));
            default: return 32'(isqrt(la + icbrt(lb)));
        endcase
    endfunction

    function automatic logic busy_of(input int idx);
        case (idx)
            0:       return busy8;
            1:       return busy16;
            default: return busy32;
        endcase
    endfunction

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q8.size();
            1:       return q16.size();
            default: return q32.size();
        endcase
    endfunction

    task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_res(input string nm, input int idx, input logic [31:0] got, input exp_t e);
        longint lat;
        lat = cyc - longint'(e.t);
        check_eq({nm, "_result"}, got, e.y);
        if (lat_ref[idx][e.md] < 0) begin
            lat_ref[idx][e.md] = lat;
        end else begin
            checks++;
            if (lat != lat_ref[idx][e.md]) begin
                errors++;
                $display("FAIL %s_latency mode %0d got %0d expected %0d", nm, e.md, lat, lat_ref[idx][e.md]);
            end
        end
    endtask

    task automatic issue(input int idx, input logic [1:0] md, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ey);
        exp_t e;
        int   n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_of(idx) && n < WAIT_LIM);
        if (busy_of(idx)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst %0d busy still 1 expected 0", idx);
        end
        e.y  = ey;
        e.md = (md == 2'b11) ? 2'b00 : md;
        e.t  = 64'(cyc);
        case (idx)
            0: begin md8 = md;  a8 = a[7:0];   b8 = b[7:0];   st8 = 1'b1;  q8.push_back(e);  end
            1: begin md16 = md; a16 = a[15:0]; b16 = b[15:0]; st16 = 1'b1; q16.push_back(e); end
            default: begin md32 = md; a32 = a; b32 = b; st32 = 1'b1; q32.push_back(e); end
        endcase
        @(negedge clk);
        case (idx)
            0:       st8 = 1'b0;
            1:       st16 = 1'b0;
            default: st32 = 1'b0;
        endcase
    endtask

    task automatic drain(input int idx);
        int n = 0;
        while (qsize(idx) != 0 && n < DRAIN_LIM) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_pending", 32'(qsize(idx)), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Monitors: pop and compare whenever a result is presented.
    logic prev8 = 1'b0, prev16 = 1'b0, prev32 = 1'b0;
    exp_t e8, e16, e32;

    always @(negedge clk) begin
        if (vld8) begin
            check_eq("w8_valid_width", 32'(prev8), 32'd0);
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL w8_unexpected_valid got y=%0d expected no result", y8);
            end else begin
                e8 = q8.pop_front();
                check_res("w8", 0, 32'(y8), e8);
            end
        end
        prev8 = vld8;
    end

    always @(negedge clk) begin
        if (vld16) begin
            check_eq("w16_valid_width", 32'(prev16), 32'd0);
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL w16_unexpected_valid got y=%0d expected no result", y16);
            end else begin
                e16 = q16.pop_front();
                check_res("w16", 1, 32'(y16), e16);
            end
        end
        prev16 = vld16;
    end

    always @(negedge clk) begin
        if (vld32) begin
            check_eq("w32_valid_width", 32'(prev32), 32'd0);
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL w32_unexpected_valid got y=%0d expected no result", y32);
            end else begin
                e32 = q32.pop_front();
                check_res("w32", 2, y32, e32);
            end
        end
        prev32 = vld32;
    end

    task automatic stream8();
        exp_t e;
        int   n;
        issue(0, 2'b00, 10, 27, 3);
        issue(0, 2'b00, 0, 0, 0);
        issue(0, 2'b00, 255, 255, 16);
        issue(0, 2'b11, 10, 27, 3);
        issue(0, 2'b10, 0, 125, 5);
        issue(0, 2'b10, 0, 124, 4);
        issue(0, 2'b10, 0, 255, 6);
        issue(0, 2'b01, 200, 0, 14);
        issue(0, 2'b01, 255, 0, 15);
        // start held high for three cycles: exactly one result expected
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy8 && n < WAIT_LIM);
        e.y = 32'd15; e.md = 2'b01; e.t = 64'(cyc);
        q8.push_back(e);
        md8 = 2'b01; a8 = 8'd255; b8 = 8'd0; st8 = 1'b1;
        repeat (3) @(negedge clk);
        st8 = 1'b0;
        // reset in the middle of the square-root iterations
        issue(0, 2'b01, 200, 0, 14);
        @(negedge clk);
        check_eq("w8_busy_before_reset", 32'(busy8), 32'd1);
        check_eq("w8_y_held_before_reset", 32'(y8), 32'd15);
        rst8_n = 1'b0;
        #1;
        check_eq("w8_busy_async_reset", 32'(busy8), 32'd0);
        check_eq("w8_valid_async_reset", 32'(vld8), 32'd0);
        check_eq("w8_y_async_reset", 32'(y8), 32'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst8_n = 1'b1;
        issue(0, 2'b01, 16, 0, 4);
        drain(0);
    endtask

    task automatic stream16();
        issue(1, 2'b00, 65535, 65535, 256);
        issue(1, 2'b11, 0, 0, 0);
        issue(1, 2'b10, 0, 65535, 40);
        issue(1, 2'b01, 65535, 0, 255);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            logic [1:0]  rm;
            ra = $urandom & 32'h0000_FFFF;
            rb = $urandom & 32'h0000_FFFF;
            rm = 2'($urandom_range(0, 3));
            issue(1, rm, ra, rb, ref_root(rm, ra, rb));
        end
        drain(1);
    endtask

    task automatic stream32();
        issue(2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 65536);
        issue(2, 2'b10, 0, 32'hFFFF_FFFF, 1625);
        issue(2, 2'b01, 32'hFFFF_FFFF, 0, 65535);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            logic [1:0]  rm;
            ra = $urandom;
            rb = $urandom;
            rm = 2'($urandom_range(0, 3));
            issue(2, rm, ra, rb, ref_root(rm, ra, rb));
        end
        drain(2);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                lat_ref[i][j] = -1;
        #2;
        check_eq("w8_reset_busy", 32'(busy8), 32'd0);
        check_eq("w8_reset_valid", 32'(vld8), 32'd0);
        check_eq("w8_reset_y", 32'(y8), 32'd0);
        check_eq("w16_reset_y", 32'(y16), 32'd0);
        check_eq("w32_reset_busy", 32'(busy32), 32'd0);
        check_eq("w32_reset_y", y32, 32'd0);
        repeat (2) @(negedge clk);
        rst8_n = 1'b1;
        rstw_n = 1'b1;
        fork
            stream8();
            stream16();
            stream32();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached with %0d errors so far", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
